// File: rtl/bus_responder_if.sv
// CPU bus between the processor (master) and the memory-side responder (slave).
interface bus_responder_if;
    logic [15:0] address;
    logic        read_write;   // 1 = read, 0 = write
    logic [7:0]  data_write;
    logic [7:0]  data_read;

    modport master (
        output address,
        output read_write,
        output data_write,
        input  data_read
    );

    modport slave (
        input  address,
        input  read_write,
        input  data_write,
        output data_read
    );
endinterface

// File: rtl/bus_responder.sv
// Memory-side bus endpoint: on-chip RAM, reset/IRQ vector ROM, 8-bit GPIO and a
// reloading down-counter with a sticky expiry flag and level interrupt.
module bus_responder #(
    parameter int unsigned RAM_AW    = 11,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [15:0] IRQ_VEC   = 16'h0300,
    parameter logic [7:0]  OPEN_BUS  = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_responder_if.slave        bus,
    input  logic [7:0]            gpio_in,
    output logic [7:0]            gpio_out,
    output logic                  timer_irq
);

    localparam int unsigned RamDepth = 1 << RAM_AW;

    localparam logic [15:0] AddrGpioOut  = 16'hF000;
    localparam logic [15:0] AddrGpioIn   = 16'hF001;
    localparam logic [15:0] AddrReload   = 16'hF002;
    localparam logic [15:0] AddrCount    = 16'hF003;
    localparam logic [15:0] AddrCtrl     = 16'hF004;
    localparam logic [15:0] AddrStatus   = 16'hF005;
    localparam logic [15:0] AddrResetLo  = 16'hFFFC;
    localparam logic [15:0] AddrResetHi  = 16'hFFFD;
    localparam logic [15:0] AddrIrqLo    = 16'hFFFE;
    localparam logic [15:0] AddrIrqHi    = 16'hFFFF;

    logic [7:0] mem [RamDepth];

    logic [7:0] data_read_q, data_read_d;
    logic [7:0] gpio_out_q, gpio_out_d;
    logic [7:0] sync1_q, sync2_q;
    logic [7:0] reload_q, reload_d;
    logic [7:0] count_q, count_d;
    logic       enable_q, enable_d;
    logic       irq_en_q, irq_en_d;
    logic       expired_q, expired_d;

    logic              in_ram;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_write;
    logic              wr_ram;
    logic              wr_gpio;
    logic              wr_reload;
    logic              wr_ctrl;
    logic              rd_status;
    logic              expire;

    // Address decode shared by the read mux and the write enables.
    assign in_ram    = 32'(bus.address) < RamDepth;
    assign ram_idx   = bus.address[RAM_AW-1:0];
    assign is_write  = ~bus.read_write;
    assign wr_ram    = is_write & in_ram;
    assign wr_gpio   = is_write & (bus.address == AddrGpioOut);
    assign wr_reload = is_write & (bus.address == AddrReload);
    assign wr_ctrl   = is_write & (bus.address == AddrCtrl);
    assign rd_status = bus.read_write & (bus.address == AddrStatus);
    assign expire    = enable_q & (count_q == 8'h00);

    // Read mux: always reflects pre-edge contents, so writes see read-before-write data.
    always_comb begin
        data_read_d = OPEN_BUS;
        if (in_ram) begin
            data_read_d = mem[ram_idx];
        end else begin
            case (bus.address)
                AddrGpioOut: data_read_d = gpio_out_q;
                AddrGpioIn:  data_read_d = sync2_q;
                AddrReload:  data_read_d = reload_q;
                AddrCount:   data_read_d = count_q;
                AddrCtrl:    data_read_d = {6'b0, irq_en_q, enable_q};
                AddrStatus:  data_read_d = {7'b0, expired_q};
                AddrResetLo: data_read_d = RESET_VEC[7:0];
                AddrResetHi: data_read_d = RESET_VEC[15:8];
                AddrIrqLo:   data_read_d = IRQ_VEC[7:0];
                AddrIrqHi:   data_read_d = IRQ_VEC[15:8];
                default:     data_read_d = OPEN_BUS;
            endcase
        end
    end

    // Register and timer next-state; a reload write overrides the counter's own reload,
    // and an expiry beats a coincident status-read clear.
    always_comb begin
        gpio_out_d = gpio_out_q;
        reload_d   = reload_q;
        count_d    = count_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        expired_d  = expired_q;

        if (wr_gpio) begin
            gpio_out_d = bus.data_write;
        end
        if (wr_ctrl) begin
            enable_d = bus.data_write[0];
            irq_en_d = bus.data_write[1];
        end
        if (enable_q) begin
            count_d = expire ? reload_q : count_q - 8'd1;
        end
        if (wr_reload) begin
            reload_d = bus.data_write;
            count_d  = bus.data_write;
        end
        if (rd_status) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    // RAM write port; contents are not reset, but a write under reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_ram) begin
            mem[ram_idx] <= bus.data_write;
        end
    end

    // All non-RAM state, including the two-flop GPIO input synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_read_q <= 8'h00;
            gpio_out_q  <= 8'h00;
            sync1_q     <= 8'h00;
            sync2_q     <= 8'h00;
            reload_q    <= 8'h00;
            count_q     <= 8'h00;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            data_read_q <= data_read_d;
            gpio_out_q  <= gpio_out_d;
            sync1_q     <= gpio_in;
            sync2_q     <= sync1_q;
            reload_q    <= reload_d;
            count_q     <= count_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            expired_q   <= expired_d;
        end
    end

    assign bus.data_read = data_read_q;
    assign gpio_out      = gpio_out_q;
    assign timer_irq     = expired_q & irq_en_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a behavioural model.
module tb_bus_responder;

    localparam logic [15:0] ResetVec = 16'h0200;
    localparam logic [15:0] IrqVec   = 16'h0300;
    localparam int          RamSize  = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       timer_irq;

    bus_responder_if bus_if ();

    bus_responder #(
        .RAM_AW   (11),
        .RESET_VEC(ResetVec),
        .IRQ_VEC  (IrqVec),
        .OPEN_BUS (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [7:0] m_mem [RamSize];
    bit         m_valid [RamSize];
    int         m_gpio, m_reload, m_count, m_en, m_ie, m_exp, m_s1, m_s2;
    int         m_rd;
    bit         m_rd_known;
    bit         started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_edge();
        int a;
        int d;
        bit rd;
        bit expire;
        a  = int'(bus_if.address);
        d  = int'(bus_if.data_write);
        rd = bus_if.read_write;
        if (rst) begin
            started = 1'b1;
            m_gpio = 0; m_reload = 0; m_count = 0; m_en = 0; m_ie = 0; m_exp = 0;
            m_s1 = 0; m_s2 = 0;
            m_rd = 0; m_rd_known = 1'b1;
            return;
        end
        m_rd_known = 1'b1;
        if (a < RamSize) begin
            m_rd_known = m_valid[a];
            m_rd       = int'(m_mem[a]);
        end else begin
            case (a)
                'hF000:  m_rd = m_gpio;
                'hF001:  m_rd = m_s2;
                'hF002:  m_rd = m_reload;
                'hF003:  m_rd = m_count;
                'hF004:  m_rd = m_en + 2 * m_ie;
                'hF005:  m_rd = m_exp;
                'hFFFC:  m_rd = int'(ResetVec) % 256;
                'hFFFD:  m_rd = int'(ResetVec) / 256;
                'hFFFE:  m_rd = int'(IrqVec) % 256;
                'hFFFF:  m_rd = int'(IrqVec) / 256;
                default: m_rd = 0;
            endcase
        end
        expire = (m_en == 1) && (m_count == 0);
        if (m_en == 1) m_count = (m_count == 0) ? m_reload : m_count - 1;
        if (!rd) begin
            if (a < RamSize) begin
                m_mem[a]   = 8'(d);
                m_valid[a] = 1'b1;
            end
            case (a)
                'hF000: m_gpio = d;
                'hF002: begin m_reload = d; m_count = d; end
                'hF004: begin m_en = d % 2; m_ie = (d / 2) % 2; end
                default: ;
            endcase
        end
        if (rd && a == 'hF005) m_exp = 0;
        if (expire) m_exp = 1;
        m_s2 = m_s1;
        m_s1 = int'(gpio_in);
    endtask

    // Single compare process: model steps at each edge, outputs sampled 1 time unit later.
    always @(posedge clk) begin
        model_edge();
        #1;
        if (started) begin
            if (m_rd_known) chk("model data_read", {24'h0, bus_if.data_read}, m_rd);
            chk("model gpio_out", {24'h0, gpio_out}, m_gpio);
            chk("model timer_irq", {31'h0, timer_irq}, (m_exp != 0 && m_ie != 0) ? 1 : 0);
        end
    end

    // One bus cycle: inputs driven on the falling edge, returns 2 units after the rising edge.
    task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d,
                       input logic r = 1'b0);
        @(negedge clk);
        rst                = r;
        bus_if.address     = a;
        bus_if.read_write  = rw;
        bus_if.data_write  = d;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] cnt_seq [5];
    logic [15:0] ra;
    logic       rrw;
    logic [7:0] rd8;

    initial begin
        rst               = 1'b1;
        bus_if.address    = 16'h0000;
        bus_if.read_write = 1'b1;
        bus_if.data_write = 8'h00;
        gpio_in           = 8'h00;
        cnt_seq[0] = 8'd3; cnt_seq[1] = 8'd2; cnt_seq[2] = 8'd1; cnt_seq[3] = 8'd0;
        cnt_seq[4] = 8'd3;

        // Reset state
        cyc(16'h0000, 1'b1, 8'h00, 1'b1);
        cyc(16'h0000, 1'b1, 8'h00, 1'b1);
        chk("reset data_read", {24'h0, bus_if.data_read}, 32'h00);
        chk("reset gpio_out", {24'h0, gpio_out}, 32'h00);
        chk("reset timer_irq", {31'h0, timer_irq}, 32'h0);

        // Vector ROM and open bus
        cyc(16'hFFFC, 1'b1, 8'h00); chk("vec FFFC", {24'h0, bus_if.data_read}, 32'h00);
        cyc(16'hFFFD, 1'b1, 8'h00); chk("vec FFFD", {24'h0, bus_if.data_read}, 32'h02);
        cyc(16'hFFFE, 1'b1, 8'h00); chk("vec FFFE", {24'h0, bus_if.data_read}, 32'h00);
        cyc(16'hFFFF, 1'b1, 8'h00); chk("vec FFFF", {24'h0, bus_if.data_read}, 32'h03);
        cyc(16'h8000, 1'b1, 8'h00); chk("open 8000", {24'h0, bus_if.data_read}, 32'h00);

        // RAM write/read and read-during-write
        cyc(16'h0010, 1'b0, 8'hA5);
        cyc(16'h07FF, 1'b0, 8'h3C);
        cyc(16'h0010, 1'b1, 8'h00); chk("ram 0010", {24'h0, bus_if.data_read}, 32'hA5);
        cyc(16'h07FF, 1'b1, 8'h00); chk("ram 07FF", {24'h0, bus_if.data_read}, 32'h3C);
        cyc(16'h0010, 1'b0, 8'h11); chk("ram rbw", {24'h0, bus_if.data_read}, 32'hA5);
        cyc(16'h0010, 1'b1, 8'h00); chk("ram after rbw", {24'h0, bus_if.data_read}, 32'h11);

        // GPIO out and synchronised input
        cyc(16'hF000, 1'b0, 8'h81); chk("gpio_out", {24'h0, gpio_out}, 32'h81);
        gpio_in = 8'h5A;
        cyc(16'hF001, 1'b1, 8'h00); chk("gpio_in edge1", {24'h0, bus_if.data_read}, 32'h00);
        cyc(16'hF001, 1'b1, 8'h00); chk("gpio_in edge2", {24'h0, bus_if.data_read}, 32'h00);
        cyc(16'hF001, 1'b1, 8'h00); chk("gpio_in edge3", {24'h0, bus_if.data_read}, 32'h5A);

        // Timer: reload 3, enable with irq
        cyc(16'hF002, 1'b0, 8'h03);
        cyc(16'hF004, 1'b0, 8'h03);
        for (int i = 0; i < 5; i++) begin
            cyc(16'hF003, 1'b1, 8'h00);
            chk("timer count seq", {24'h0, bus_if.data_read}, {24'h0, cnt_seq[i]});
            if (i == 2) chk("irq before expiry", {31'h0, timer_irq}, 32'h0);
            if (i == 3) chk("irq at expiry", {31'h0, timer_irq}, 32'h1);
        end
        cyc(16'hF005, 1'b1, 8'h00); chk("status read", {24'h0, bus_if.data_read}, 32'h01);
        chk("irq cleared", {31'h0, timer_irq}, 32'h0);
        cyc(16'hF003, 1'b1, 8'h00); chk("count mid", {24'h0, bus_if.data_read}, 32'h01);
        cyc(16'hF005, 1'b1, 8'h00); chk("status coincident", {24'h0, bus_if.data_read}, 32'h00);
        chk("irq set wins", {31'h0, timer_irq}, 32'h1);
        cyc(16'hF005, 1'b1, 8'h00); chk("status kept", {24'h0, bus_if.data_read}, 32'h01);
        for (int i = 0; i < 3; i++) cyc(16'hF003, 1'b1, 8'h00);
        chk("irq before reset", {31'h0, timer_irq}, 32'h1);

        // Reset mid-count with a coincident RAM write
        cyc(16'h0020, 1'b0, 8'h77);
        cyc(16'h0020, 1'b0, 8'hEE, 1'b1);
        chk("rst gpio_out", {24'h0, gpio_out}, 32'h00);
        chk("rst timer_irq", {31'h0, timer_irq}, 32'h0);
        chk("rst data_read", {24'h0, bus_if.data_read}, 32'h00);
        cyc(16'hF003, 1'b1, 8'h00); chk("rst count", {24'h0, bus_if.data_read}, 32'h00);
        cyc(16'hF004, 1'b1, 8'h00); chk("rst ctrl", {24'h0, bus_if.data_read}, 32'h00);
        cyc(16'h0020, 1'b1, 8'h00); chk("rst ram kept", {24'h0, bus_if.data_read}, 32'h77);

        // Randomized traffic, checked by the model on every cycle
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    ra = 16'($urandom_range(0, 15));
                2:       ra = 16'h07F0 + 16'($urandom_range(0, 15));
                3:       ra = 16'hF000 + 16'($urandom_range(0, 6));
                4:       ra = 16'hFFFC + 16'($urandom_range(0, 3));
                default: ra = 16'($urandom);
            endcase
            rrw = ($urandom_range(0, 9) < 6);
            rd8 = 8'($urandom);
            if (ra == 16'hF002) rd8 = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            cyc(ra, rrw, rd8, ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
